vram_arbiter: RTL and testbench

- Shares one external asynchronous video SRAM between two requesters: the scan-out fetch path and the CPU bus interface.
- The video path has hard priority, and its worst-case latency is bounded.
- The CPU gets all remaining access slots through a req/ack handshake.
- Sits between the VGA timing/pixel pipeline and the board SRAM pins. It is clocked by the pixel clock.

---
 rtl/vram_arbiter.sv | 158 +++++++++++++++
 tb/tb_vram_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one asynchronous video SRAM between the scan-out
// fetch path (hard priority, bounded latency) and the CPU bus interface
// (gets every remaining slot through a req/ack handshake). Clocked by the
// pixel clock.
//
// Ports:
//   clk, rst          pixel clock, asynchronous active-high reset
//   en                arbiter enable; low = no new access started
//   vid_req/vid_addr  one-cycle fetch strobe and address from scan-out
//   vid_data/vid_valid fetched byte with one-cycle valid pulse
//   vid_ovf           sticky: a fetch strobe arrived while one was pending
//   cpu_req/cpu_we/cpu_addr/cpu_wdata  CPU request, held until cpu_ack
//   cpu_rdata/cpu_ack read data and one-cycle completion pulse
//   mem_*             SRAM pins (address, write data + tristate enable,
//                     read data, active-low output and write enables)
//
// Handshakes:
//   video: vid_req is a single-cycle strobe that is always accepted; the
//     result appears later as a one-cycle vid_valid pulse. A strobe that
//     arrives while an earlier one is still pending replaces its address
//     and raises vid_ovf; only one fetch is done.
//   cpu: cpu_req is a level held (with stable we/addr/wdata) until the
//     one-cycle cpu_ack pulse. cpu_req is ignored while cpu_ack is high, so
//     a request still held during the ack cycle is not issued twice.
module vram_arbiter #(
  parameter int ADDR_W  = 15,
  parameter int DATA_W  = 8,
  parameter int ACC_CYC = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic [DATA_W-1:0] vid_data,
  output logic              vid_valid,
  output logic              vid_ovf,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_dout,
  output logic              mem_dout_en,
  input  logic [DATA_W-1:0] mem_din,
  output logic              mem_oe_n,
  output logic              mem_we_n
);

  localparam int CW = (ACC_CYC > 2) ? $clog2(ACC_CYC) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_VID    = 2'd1,
    S_CPU_RD = 2'd2,
    S_CPU_WR = 2'd3
  } state_t;

  state_t            state;
  logic [CW-1:0]     acc_cnt;
  logic              vid_pend;
  logic [ADDR_W-1:0] vid_addr_q;

  logic          vid_go;
  logic          cnt_last;
  logic [CW-1:0] cnt_next;
  logic          we_low_next;

  // A video fetch starts from IDLE whenever one is pending or strobed now.
  assign vid_go   = (state == S_IDLE) && en && (vid_pend || vid_req);
  assign cnt_last = (acc_cnt == CW'(ACC_CYC - 1));
  assign cnt_next = acc_cnt + CW'(1);
  // Write strobe is low from the second access cycle on; for accesses longer
  // than two cycles it is released one cycle early for data hold.
  assign we_low_next = (ACC_CYC == 2) || (cnt_next != CW'(ACC_CYC - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      acc_cnt     <= '0;
      vid_pend    <= 1'b0;
      vid_addr_q  <= '0;
      vid_ovf     <= 1'b0;
      vid_data    <= '0;
      vid_valid   <= 1'b0;
      cpu_rdata   <= '0;
      cpu_ack     <= 1'b0;
      mem_addr    <= '0;
      mem_dout    <= '0;
      mem_dout_en <= 1'b0;
      mem_oe_n    <= 1'b1;
      mem_we_n    <= 1'b1;
    end else begin
      vid_valid <= 1'b0;
      cpu_ack   <= 1'b0;

      // Pending-fetch bookkeeping. Consumption wins over a new strobe on the
      // same edge because the strobe's address is used directly.
      if (vid_go) begin
        vid_pend <= 1'b0;
      end else if (vid_req) begin
        vid_pend   <= 1'b1;
        vid_addr_q <= vid_addr;
        if (vid_pend) vid_ovf <= 1'b1;
      end

      case (state)
        S_IDLE: begin
          acc_cnt <= '0;
          if (vid_go) begin
            state    <= S_VID;
            mem_addr <= vid_req ? vid_addr : vid_addr_q;
            mem_oe_n <= 1'b0;
          end else if (en && cpu_req && !cpu_ack) begin
            mem_addr <= cpu_addr;
            if (cpu_we) begin
              state       <= S_CPU_WR;
              mem_dout    <= cpu_wdata;
              mem_dout_en <= 1'b1;
            end else begin
              state    <= S_CPU_RD;
              mem_oe_n <= 1'b0;
            end
          end
        end

        default: begin
          if (cnt_last) begin
            state       <= S_IDLE;
            acc_cnt     <= '0;
            mem_oe_n    <= 1'b1;
            mem_we_n    <= 1'b1;
            mem_dout_en <= 1'b0;
            case (state)
              S_VID: begin
                vid_data  <= mem_din;
                vid_valid <= 1'b1;
              end
              S_CPU_RD: begin
                cpu_rdata <= mem_din;
                cpu_ack   <= 1'b1;
              end
              default: begin
                cpu_ack <= 1'b1;
              end
            endcase
          end else begin
            acc_cnt <= cnt_next;
            if (state == S_CPU_WR) mem_we_n <= !we_low_next;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
`timescale 1ns/1ps
module tb_vram_arbiter;
  localparam int AW = 15;
  localparam int DW = 8;
  localparam int AC = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          en, vid_req, cpu_req, cpu_we;
  logic [AW-1:0] vid_addr, cpu_addr, mem_addr;
  logic [DW-1:0] vid_data, cpu_wdata, cpu_rdata, mem_dout, mem_din;
  logic          vid_valid, vid_ovf, cpu_ack, mem_dout_en, mem_oe_n, mem_we_n;

  vram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ACC_CYC(AC)) dut (
    .clk(clk), .rst(rst), .en(en),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_data(vid_data),
    .vid_valid(vid_valid), .vid_ovf(vid_ovf),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .mem_addr(mem_addr), .mem_dout(mem_dout), .mem_dout_en(mem_dout_en),
    .mem_din(mem_din), .mem_oe_n(mem_oe_n), .mem_we_n(mem_we_n)
  );

  // Board SRAM: asynchronous read, write taken while the strobe is low.
  logic [DW-1:0] sram [0:(1<<AW)-1];
  assign mem_din = sram[mem_addr];
  always @(posedge clk) if (!mem_we_n) sram[mem_addr] <= mem_dout;

  // Reference memory: updated when a CPU write is issued, transaction level.
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  logic [DW-1:0] last_rd;

  // ---------------- scoreboard ----------------
  logic [DW-1:0] exp_vid_q[$];
  int            vid_lo_q[$], vid_hi_q[$];
  logic [DW-1:0] exp_cpu_q[$];
  int            cpu_lo_q[$], cpu_hi_q[$];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk_win(input string nm, input int act, input int lo, input int hi);
    total++;
    if (act < lo || act > hi) begin
      bad++;
      $display("FAIL %s: got cycle %0d want %0d..%0d", nm, act, lo, hi);
    end
  endtask

  task automatic push_vid(input logic [AW-1:0] a, input int lo, input int hi);
    exp_vid_q.push_back(ref_mem[a]);
    vid_lo_q.push_back(lo);
    vid_hi_q.push_back(hi);
  endtask

  task automatic push_cpu(input logic [DW-1:0] d, input int lo, input int hi);
    exp_cpu_q.push_back(d);
    cpu_lo_q.push_back(lo);
    cpu_hi_q.push_back(hi);
  endtask

  // Monitor: pops and compares whenever the DUT presents a result.
  always @(negedge clk) begin
    if (!rst) begin
      if (vid_valid) begin
        if (exp_vid_q.size() == 0) begin
          total++; bad++;
          $display("FAIL vid_unexpected: got fetch data %0h want no fetch (cycle %0d)", vid_data, cyc);
        end else begin
          chk("vid_data", vid_data, exp_vid_q.pop_front());
          chk_win("vid_latency", cyc, vid_lo_q.pop_front(), vid_hi_q.pop_front());
        end
      end
      if (cpu_ack) begin
        if (exp_cpu_q.size() == 0) begin
          total++; bad++;
          $display("FAIL cpu_unexpected: got ack rdata %0h want no ack (cycle %0d)", cpu_rdata, cyc);
        end else begin
          chk("cpu_rdata", cpu_rdata, exp_cpu_q.pop_front());
          chk_win("cpu_latency", cyc, cpu_lo_q.pop_front(), cpu_hi_q.pop_front());
        end
      end
      if (!mem_we_n) chk("we_excl", {mem_oe_n, mem_dout_en}, 2'b11);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) tick();
  endtask

  task automatic set_cpu(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
  endtask

  // Expected read-data value seen at ack for a CPU access issued now.
  function automatic logic [DW-1:0] cpu_model(input logic we, input logic [AW-1:0] a,
                                              input logic [DW-1:0] d);
    if (we) begin
      ref_mem[a] = d;
      return last_rd;
    end
    last_rd = ref_mem[a];
    return last_rd;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test want finish");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

  int c, act_cnt;
  logic [DW-1:0] e;

  initial begin
    en = 1'b1; vid_req = 1'b0; vid_addr = '0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    last_rd = '0;
    for (int i = 0; i < (1 << AW); i++) begin
      e = DW'($urandom);
      sram[i] = e;
      ref_mem[i] = e;
    end

    // Reset values, checked while reset is held.
    #1 rst = 1'b1;
    #2;
    chk("rst_oe_n", mem_oe_n, 1'b1);
    chk("rst_we_n", mem_we_n, 1'b1);
    chk("rst_dout_en", mem_dout_en, 1'b0);
    chk("rst_mem_addr", mem_addr, 15'h0);
    chk("rst_mem_dout", mem_dout, 8'h0);
    chk("rst_vid_valid", vid_valid, 1'b0);
    chk("rst_vid_data", vid_data, 8'h0);
    chk("rst_vid_ovf", vid_ovf, 1'b0);
    chk("rst_cpu_ack", cpu_ack, 1'b0);
    chk("rst_cpu_rdata", cpu_rdata, 8'h0);
    tick(); tick();
    rst = 1'b0;
    tick(); tick();

    // Idle video fetch: address on the pins for AC cycles, data one later.
    sram[15'h1234] = 8'hA5; ref_mem[15'h1234] = 8'hA5;
    tick(); vid_req = 1'b1; vid_addr = 15'h1234; c = cyc;
    push_vid(15'h1234, c + AC + 1, c + AC + 1);
    tick(); vid_req = 1'b0; #2;
    chk("idle_addr_c1", mem_addr, 15'h1234);
    chk("idle_oe_c1", mem_oe_n, 1'b0);
    tick(); #2;
    chk("idle_addr_c2", mem_addr, 15'h1234);
    chk("idle_oe_c2", mem_oe_n, 1'b0);
    tick(); #2;
    chk("idle_oe_c3", mem_oe_n, 1'b1);
    wait_until(c + 6);

    // CPU write then read of the same address; request held through ack.
    tick(); set_cpu(1'b1, 15'h0010, 8'h5A); c = cyc;
    push_cpu(cpu_model(1'b1, 15'h0010, 8'h5A), c + AC + 1, c + AC + 1);
    tick(); #2;
    chk("wr_setup_we_n", mem_we_n, 1'b1);
    chk("wr_dout_en", mem_dout_en, 1'b1);
    chk("wr_dout", mem_dout, 8'h5A);
    chk("wr_oe_n", mem_oe_n, 1'b1);
    chk("wr_addr", mem_addr, 15'h0010);
    tick(); #2;
    chk("wr_strobe_we_n", mem_we_n, 1'b0);
    tick(); #2;
    chk("wr_exit_we_n", mem_we_n, 1'b1);
    tick(); cpu_we = 1'b0;
    push_cpu(cpu_model(1'b0, 15'h0010, 8'h00), cyc + AC + 1, cyc + AC + 1);
    #2;
    chk("no_dup_access", {mem_oe_n, mem_dout_en}, 2'b10);
    wait_until(c + 3 + AC + 2);
    cpu_req = 1'b0;
    wait_until(c + 12);

    // Contention in IDLE: video first, CPU after one turnaround cycle.
    tick(); vid_req = 1'b1; vid_addr = 15'h4100; set_cpu(1'b0, 15'h0020, 8'h00); c = cyc;
    push_vid(15'h4100, c + AC + 1, c + AC + 1);
    push_cpu(cpu_model(1'b0, 15'h0020, 8'h00), c + 2 * AC + 2, c + 2 * AC + 2);
    tick(); vid_req = 1'b0;
    wait_until(c + 2 * AC + 2);
    cpu_req = 1'b0;
    wait_until(c + 10);

    // Video strobe in the first cycle of a CPU access: CPU runs AC cycles,
    // one turnaround, then AC video cycles -> valid 2*AC+1 after the strobe;
    // 2*AC+2 is the worst-case bound.
    tick(); set_cpu(1'b0, 15'h0030, 8'h00); c = cyc;
    push_cpu(cpu_model(1'b0, 15'h0030, 8'h00), c + AC + 1, c + AC + 1);
    tick(); vid_req = 1'b1; vid_addr = 15'h4200;
    push_vid(15'h4200, cyc + 2 * AC + 1, cyc + 2 * AC + 2);
    tick(); vid_req = 1'b0;
    wait_until(c + AC + 1);
    cpu_req = 1'b0;
    wait_until(c + 12);

    // Overflow: two back-to-back strobes during a CPU write.
    chk("ovf_before", vid_ovf, 1'b0);
    tick(); set_cpu(1'b1, 15'h0040, 8'h3C); c = cyc;
    push_cpu(cpu_model(1'b1, 15'h0040, 8'h3C), c + AC + 1, c + AC + 1);
    tick(); vid_req = 1'b1; vid_addr = 15'h4300;
    tick(); vid_addr = 15'h4400;
    push_vid(15'h4400, c + 2 * AC + 2, c + 2 * AC + 2);
    tick(); vid_req = 1'b0; cpu_req = 1'b0; #2;
    chk("ovf_set", vid_ovf, 1'b1);
    wait_until(c + 12);
    chk("ovf_sticky", vid_ovf, 1'b1);

    // en=0: requests wait with the bus idle; video is served first on en=1.
    tick(); en = 1'b0; vid_req = 1'b1; vid_addr = 15'h4500; set_cpu(1'b0, 15'h0050, 8'h00); c = cyc;
    push_vid(15'h4500, c + 10 + AC + 1, c + 10 + AC + 1);
    push_cpu(cpu_model(1'b0, 15'h0050, 8'h00), c + 10 + 2 * AC + 2, c + 10 + 2 * AC + 2);
    tick(); vid_req = 1'b0;
    act_cnt = 0;
    for (int i = 0; i < 9; i++) begin
      #2;
      if (!mem_oe_n || !mem_we_n || mem_dout_en) act_cnt++;
      tick();
    end
    chk("en0_no_activity", act_cnt, 0);
    wait_until(c + 10); en = 1'b1;
    wait_until(c + 10 + 2 * AC + 2);
    cpu_req = 1'b0;
    wait_until(c + 20);

    // Reset in the strobe cycle of a write: pins released at once, no ack.
    tick(); set_cpu(1'b1, 15'h0060, 8'h77); c = cyc;
    tick(); tick(); #1;
    chk("rstw_pre_we_n", mem_we_n, 1'b0);
    #1 rst = 1'b1;
    #1;
    chk("rstw_we_n", mem_we_n, 1'b1);
    chk("rstw_dout_en", mem_dout_en, 1'b0);
    chk("rstw_cpu_ack", cpu_ack, 1'b0);
    cpu_req = 1'b0;
    last_rd = '0;
    tick(); tick();
    rst = 1'b0;
    #2;
    chk("rstw_ovf_clr", vid_ovf, 1'b0);
    chk("rstw_rdata_clr", cpu_rdata, 8'h0);
    // Arbiter must be back in IDLE: an idle-latency fetch proves it.
    tick(); vid_req = 1'b1; vid_addr = 15'h4600; c = cyc;
    push_vid(15'h4600, c + AC + 1, c + AC + 1);
    tick(); vid_req = 1'b0;
    wait_until(c + 6);

    // Randomized traffic: video in the upper half, CPU in the lower half.
    fork
      begin
        int n;
        logic [AW-1:0] a;
        for (int k = 0; k < 40; k++) begin
          repeat ($urandom_range(0, 5)) tick();
          n = 0;
          while (exp_vid_q.size() != 0 && n < 50) begin tick(); n++; end
          chk("vid_drain", exp_vid_q.size(), 0);
          tick();
          a = {1'b1, 14'($urandom)};
          vid_req = 1'b1; vid_addr = a;
          push_vid(a, cyc + AC + 1, cyc + 2 * AC + 2);
          tick(); vid_req = 1'b0;
        end
      end
      begin
        bit got;
        logic we;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        for (int k = 0; k < 40; k++) begin
          repeat ($urandom_range(0, 4)) tick();
          tick();
          we = 1'($urandom);
          a = {1'b0, 14'($urandom_range(0, 63))};
          d = DW'($urandom);
          set_cpu(we, a, d);
          push_cpu(cpu_model(we, a, d), cyc + AC + 1, cyc + 2 * AC + 2);
          got = 1'b0;
          for (int w = 0; w < 40 && !got; w++) begin
            tick(); #2;
            got = cpu_ack;
          end
          cpu_req = 1'b0;
          chk("cpu_ack_seen", got, 1'b1);
        end
      end
    join
    repeat (12) tick();

    chk("vid_q_empty", exp_vid_q.size(), 0);
    chk("cpu_q_empty", exp_cpu_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
